// File: rtl/ram_bus_master.sv
// rtl/ram_bus_master.sv - single-request RAM bus master with programmable wait states
// Optional odd-word-address trap: define RAM_BUS_MASTER_ODD_TRAP_EN.
module ram_bus_master #(
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic        byte_op,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    output logic        ack,
    output logic        err,
    output logic        busy,
    output logic [15:0] ram_addr,
    output logic [15:0] ram_di,
    input  logic [15:0] ram_do,
    output logic        ram_ce_n,
    output logic        ram_we_n,
    output logic        ram_byte_op
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_WAIT,
        S_XFER,
        S_DONE
    } state_t;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic        r_we;
    logic        r_byte;
    logic [15:0] r_addr;
    logic [15:0] r_di;
    logic [15:0] r_rdata;
    logic        r_ce_n;
    logic        r_we_n;
    logic        r_ack;

    // Odd byte address selects the high lane of the RAM word.
    logic [15:0] w_rd_byte;
    assign w_rd_byte = {8'h00, r_addr[0] ? ram_do[15:8] : ram_do[7:0]};

`ifdef RAM_BUS_MASTER_ODD_TRAP_EN
    logic r_err;
    logic w_odd;
    assign w_odd = ~byte_op & addr[0];
    assign err   = r_err;
`else
    assign err   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_we    <= 1'b0;
            r_byte  <= 1'b0;
            r_addr  <= 16'd0;
            r_di    <= 16'd0;
            r_rdata <= 16'd0;
            r_ce_n  <= 1'b1;
            r_we_n  <= 1'b1;
            r_ack   <= 1'b0;
`ifdef RAM_BUS_MASTER_ODD_TRAP_EN
            r_err   <= 1'b0;
`endif
        end else begin
            r_ack <= 1'b0;
`ifdef RAM_BUS_MASTER_ODD_TRAP_EN
            r_err <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (req) begin
                        r_we   <= we;
                        r_byte <= byte_op;
                        r_di   <= wdata;
`ifdef RAM_BUS_MASTER_ODD_TRAP_EN
                        r_addr <= addr;
                        if (w_odd) begin
                            r_state <= S_DONE;
                            r_ack   <= 1'b1;
                            r_err   <= 1'b1;
                        end else begin
                            r_state <= S_SETUP;
                            r_ce_n  <= 1'b0;
                        end
`else
                        r_addr  <= {addr[15:1], addr[0] & byte_op};
                        r_state <= S_SETUP;
                        r_ce_n  <= 1'b0;
`endif
                    end
                end
                S_SETUP: begin
                    r_cnt <= 4'(WAIT_STATES);
                    if (WAIT_STATES > 0) begin
                        r_state <= S_WAIT;
                    end else begin
                        r_state <= S_XFER;
                        r_we_n  <= ~r_we;
                    end
                end
                S_WAIT: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt <= 4'd1) begin
                        r_state <= S_XFER;
                        r_we_n  <= ~r_we;
                    end
                end
                S_XFER: begin
                    r_state <= S_DONE;
                    r_ce_n  <= 1'b1;
                    r_we_n  <= 1'b1;
                    r_ack   <= 1'b1;
                    if (!r_we) begin
                        r_rdata <= r_byte ? w_rd_byte : ram_do;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ce_n  <= 1'b1;
                    r_we_n  <= 1'b1;
                end
            endcase
        end
    end

    assign rdata       = r_rdata;
    assign ack         = r_ack;
    assign busy        = (r_state != S_IDLE);
    assign ram_addr    = r_addr;
    assign ram_di      = r_di;
    assign ram_ce_n    = r_ce_n;
    assign ram_we_n    = r_we_n;
    assign ram_byte_op = r_byte;

endmodule

// File: tb/tb_ram_bus_master.sv
// tb/tb_ram_bus_master.sv - directed bench for ram_bus_master (WAIT_STATES 0, 1, 3)
module tb_ram_bus_master;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, req, req0, req3, we, byte_op;
    logic [15:0] addr, wdata;
    logic [15:0] zero16 = 16'd0;

    logic [15:0] rdata, ram_addr, ram_di, ram_do;
    logic        ack, err, busy, ram_ce_n, ram_we_n, ram_byte_op;

    logic [15:0] a_rdata, a_ram_addr, a_ram_di;
    logic        a_ack, a_err, a_busy, a_ram_ce_n, a_ram_we_n, a_ram_byte_op;
    logic [15:0] b_rdata, b_ram_addr, b_ram_di;
    logic        b_ack, b_err, b_busy, b_ram_ce_n, b_ram_we_n, b_ram_byte_op;

    ram_bus_master #(.WAIT_STATES(1)) u_dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .byte_op(byte_op),
        .addr(addr), .wdata(wdata), .rdata(rdata), .ack(ack), .err(err),
        .busy(busy), .ram_addr(ram_addr), .ram_di(ram_di), .ram_do(ram_do),
        .ram_ce_n(ram_ce_n), .ram_we_n(ram_we_n), .ram_byte_op(ram_byte_op)
    );

    ram_bus_master #(.WAIT_STATES(0)) u_ws0 (
        .clk(clk), .reset(reset), .req(req0), .we(we), .byte_op(byte_op),
        .addr(addr), .wdata(wdata), .rdata(a_rdata), .ack(a_ack), .err(a_err),
        .busy(a_busy), .ram_addr(a_ram_addr), .ram_di(a_ram_di), .ram_do(zero16),
        .ram_ce_n(a_ram_ce_n), .ram_we_n(a_ram_we_n), .ram_byte_op(a_ram_byte_op)
    );

    ram_bus_master #(.WAIT_STATES(3)) u_ws3 (
        .clk(clk), .reset(reset), .req(req3), .we(we), .byte_op(byte_op),
        .addr(addr), .wdata(wdata), .rdata(b_rdata), .ack(b_ack), .err(b_err),
        .busy(b_busy), .ram_addr(b_ram_addr), .ram_di(b_ram_di), .ram_do(zero16),
        .ram_ce_n(b_ram_ce_n), .ram_we_n(b_ram_we_n), .ram_byte_op(b_ram_byte_op)
    );

    // Byte-addressed RAM: odd byte lives in the high half of the word.
    logic [15:0] mem [0:32767];
    int          n_viol = 0;
    assign ram_do = mem[ram_addr[15:1]];

    always @(posedge clk) begin
        if (!ram_ce_n && !ram_we_n) begin
            if (!ram_byte_op)
                mem[ram_addr[15:1]] <= ram_di;
            else if (ram_addr[0])
                mem[ram_addr[15:1]][15:8] <= ram_di[7:0];
            else
                mem[ram_addr[15:1]][7:0] <= ram_di[7:0];
        end
        if (ram_ce_n && !ram_we_n)
            n_viol <= n_viol + 1;
    end

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    int   lat, nack, ce_low, we_low, unstable;
    logic err_ack;

    task automatic access(input logic w, input logic b, input logic [15:0] a,
                          input logic [15:0] d, input logic extra,
                          output int o_lat, output int o_nack, output int o_ce,
                          output int o_we, output int o_unst, output logic o_err);
        logic [15:0] ea;
        ea = b ? a : {a[15:1], 1'b0};
        o_lat = 0; o_nack = 0; o_ce = 0; o_we = 0; o_unst = 0; o_err = 1'b0;
        @(posedge clk); #1;
        we = w; byte_op = b; addr = a; wdata = d; req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0; we = ~w; byte_op = ~b; addr = ~a; wdata = ~d;
        for (int k = 1; k <= 12; k++) begin
            if (ack) begin
                o_nack++;
                if (o_lat == 0) begin
                    o_lat = k;
                    o_err = err;
                end
            end
            if (!ram_ce_n) begin
                o_ce++;
                if (ram_addr != ea || ram_di != d || ram_byte_op != b) o_unst++;
            end
            if (!ram_we_n) o_we++;
            req = extra && (k == 2 || ack);
            @(posedge clk); #1;
        end
        req = 1'b0;
    endtask

    initial begin
        int lat0, lat3, ce0, ce3, acks, wl;
        reset = 1'b0; req = 1'b0; req0 = 1'b0; req3 = 1'b0;
        we = 1'b0; byte_op = 1'b0; addr = 16'd0; wdata = 16'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_ce_n", ram_ce_n, 1);
        check("rst_we_n", ram_we_n, 1);
        check("rst_ack_err", {ack, err}, 0);
        check("rst_addr_di", {ram_addr, ram_di}, 0);
        check("rst_rdata_bop", {rdata, 15'd0, ram_byte_op}, 0);
        reset = 1'b1;

        access(1, 0, 16'o001000, 16'o123456, 0, lat, nack, ce_low, we_low, unstable, err_ack);
        check("wr_lat", lat, 4);
        check("wr_we_low", we_low, 1);
        check("wr_ce_low", ce_low, 3);
        check("wr_stable", unstable, 0);
        check("wr_err", err_ack, 0);

        access(0, 0, 16'o001000, 16'o000000, 0, lat, nack, ce_low, we_low, unstable, err_ack);
        check("rd_lat", lat, 4);
        check("rd_we_low", we_low, 0);
        check("rd_data", rdata, 16'o123456);

        access(1, 1, 16'o001001, 16'h12FF, 0, lat, nack, ce_low, we_low, unstable, err_ack);
        check("bwr_stable", unstable, 0);
        check("bwr_rdata_kept", rdata, 16'o123456);

        access(0, 0, 16'o001000, 16'o000000, 0, lat, nack, ce_low, we_low, unstable, err_ack);
        check("rd_after_bwr", rdata, 16'o177456);
        access(0, 1, 16'o001001, 16'o000000, 0, lat, nack, ce_low, we_low, unstable, err_ack);
        check("brd_odd", rdata, 16'o000377);
        access(0, 1, 16'o001000, 16'o000000, 0, lat, nack, ce_low, we_low, unstable, err_ack);
        check("brd_even", rdata, 16'o000056);

        access(1, 0, 16'o000500, 16'o070707, 0, lat, nack, ce_low, we_low, unstable, err_ack);
        check("wr500_rdata_kept", rdata, 16'o000056);
        access(0, 0, 16'o000501, 16'o000000, 0, lat, nack, ce_low, we_low, unstable, err_ack);
`ifdef RAM_BUS_MASTER_ODD_TRAP_EN
        check("odd_lat", lat, 1);
        check("odd_err", err_ack, 1);
        check("odd_ce_low", ce_low, 0);
        check("odd_rdata", rdata, 16'o000056);
`else
        check("odd_lat", lat, 4);
        check("odd_err", err_ack, 0);
        check("odd_rdata", rdata, 16'o070707);
`endif

        access(0, 0, 16'o001000, 16'o000000, 1, lat, nack, ce_low, we_low, unstable, err_ack);
        check("busy_req_acks", nack, 1);
        check("busy_req_lat", lat, 4);
        check("busy_req_idle", busy, 0);

        lat0 = 0; lat3 = 0; ce0 = 0; ce3 = 0;
        @(posedge clk); #1;
        we = 1'b0; byte_op = 1'b0; addr = 16'o000100; req0 = 1'b1; req3 = 1'b1;
        @(posedge clk); #1;
        req0 = 1'b0; req3 = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            if (a_ack && lat0 == 0) lat0 = k;
            if (b_ack && lat3 == 0) lat3 = k;
            if (!a_ram_ce_n) ce0++;
            if (!b_ram_ce_n) ce3++;
            @(posedge clk); #1;
        end
        check("ws0_lat", lat0, 3);
        check("ws0_ce_low", ce0, 2);
        check("ws3_lat", lat3, 6);
        check("ws3_ce_low", ce3, 5);

        acks = 0; wl = 0;
        @(posedge clk); #1;
        we = 1'b1; byte_op = 1'b0; addr = 16'o002000; wdata = 16'hBEEF; req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
        @(posedge clk); #1;
        if (!ram_we_n) wl++;
        reset = 1'b0;
        @(posedge clk); #1;
        check("rstw_busy", busy, 0);
        check("rstw_ce_we", {ram_ce_n, ram_we_n}, 2'b11);
        check("rstw_addr_di", {ram_addr, ram_di}, 0);
        check("rstw_rdata", rdata, 0);
        reset = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (ack) acks++;
            if (!ram_we_n) wl++;
            @(posedge clk); #1;
        end
        check("rstw_no_ack", acks, 0);
        check("rstw_no_we", wl, 0);
        check("rstw_mem", mem[16'o002000 >> 1] == 16'hBEEF, 0);
        check("we_without_ce", n_viol, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
